// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS program loader.
package mips_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCntHi,
    StCntLo,
    StData,
    StRun
  } state_e;

  localparam logic [7:0] CMD_IMEM = 8'h49;  // 'I'
  localparam logic [7:0] CMD_DMEM = 8'h44;  // 'D'
  localparam logic [7:0] CMD_GO   = 8'h47;  // 'G'
  localparam logic [7:0] CMD_HALT = 8'h52;  // 'R'

  // Byte address of DMEM word 0 in the MIPS memory map.
  localparam logic [31:0] DMEM_BASE = 32'h1001_0000;

endpackage

// File: rtl/mips_mem_loader_asm.sv
// Big-endian 8-to-32 word assembler with a 2-bit byte counter.
module mips_word_assembler (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clr_i,
  input  logic        shift_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [23:0] sh_q;
  logic [1:0]  cnt_q;

  // The fourth byte is combined directly so the word is ready on the accepting edge.
  assign word_o      = {sh_q, byte_i};
  assign word_done_o = shift_en_i && (cnt_q == 2'd3);

  // Shift register and byte counter; counter wraps 3 -> 0 naturally.
  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (shift_en_i) begin
      sh_q  <= {sh_q[15:0], byte_i};
      cnt_q <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/mips_mem_loader.sv
// Framed byte-stream loader for the MIPS_SCP IMEM/DMEM; gates the core reset.
module mips_mem_loader
  import mips_loader_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 128,
  parameter int unsigned DMEM_WORDS = 128,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W:0] ImemLim = (ADDR_W+1)'(IMEM_WORDS);
  localparam logic [ADDR_W:0] DmemLim = (ADDR_W+1)'(DMEM_WORDS);

  state_e            state_q, state_d;
  logic              tgt_dmem_q, tgt_dmem_d;
  logic [7:0]        cnt_hi_q, cnt_hi_d;
  logic [15:0]       words_left_q, words_left_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic              imem_we_q, imem_we_d;
  logic              dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;

  logic        accept;
  logic        in_bounds;
  logic        asm_clr;
  logic        asm_shift;
  logic [31:0] asm_word;
  logic        asm_done;

  assign in_ready  = ~reset;
  assign accept    = in_valid && in_ready;
  assign in_bounds = tgt_dmem_q ? ({1'b0, widx_q} < DmemLim) : ({1'b0, widx_q} < ImemLim);

  assign imem_we   = imem_we_q;
  assign dmem_we   = dmem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;
  assign cpu_reset = (state_q != StRun);
  assign busy      = (state_q == StCntHi) || (state_q == StCntLo) || (state_q == StData);

  mips_word_assembler u_asm (
    .clk_i       (clk),
    .reset_i     (reset),
    .clr_i       (asm_clr),
    .shift_en_i  (asm_shift),
    .byte_i      (in_data),
    .word_o      (asm_word),
    .word_done_o (asm_done)
  );

  // Frame decoding, word indexing and write-strobe scheduling.
  always_comb begin
    state_d      = state_q;
    tgt_dmem_d   = tgt_dmem_q;
    cnt_hi_d     = cnt_hi_q;
    words_left_d = words_left_q;
    widx_d       = widx_q;
    imem_we_d    = 1'b0;
    dmem_we_d    = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    asm_clr      = 1'b0;
    asm_shift    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (in_data)
            CMD_IMEM: begin
              tgt_dmem_d = 1'b0;
              state_d    = StCntHi;
            end
            CMD_DMEM: begin
              tgt_dmem_d = 1'b1;
              state_d    = StCntHi;
            end
            CMD_GO:   state_d = StRun;
            CMD_HALT: ;
            default:  err_d = 1'b1;
          endcase
        end
      end
      StCntHi: begin
        if (accept) begin
          cnt_hi_d = in_data;
          state_d  = StCntLo;
        end
      end
      StCntLo: begin
        if (accept) begin
          if ({cnt_hi_q, in_data} == 16'd0) begin
            state_d = StIdle;
          end else begin
            words_left_d = {cnt_hi_q, in_data};
            widx_d       = '0;
            asm_clr      = 1'b1;
            state_d      = StData;
          end
        end
      end
      StData: begin
        asm_shift = accept;
        if (asm_done) begin
          if (in_bounds) begin
            imem_we_d = ~tgt_dmem_q;
            dmem_we_d = tgt_dmem_q;
            addr_d    = widx_q;
            wdata_d   = asm_word;
          end else begin
            err_d = 1'b1;
          end
          // Saturate rather than wrap so an overflowing frame never aliases low words.
          if (widx_q != {ADDR_W{1'b1}}) begin
            widx_d = widx_q + 1'b1;
          end
          words_left_d = words_left_q - 16'd1;
          if (words_left_q == 16'd1) begin
            state_d = StIdle;
          end
        end
      end
      StRun: begin
        if (accept && (in_data == CMD_HALT)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      tgt_dmem_q   <= 1'b0;
      cnt_hi_q     <= '0;
      words_left_q <= '0;
      widx_q       <= '0;
      imem_we_q    <= 1'b0;
      dmem_we_q    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tgt_dmem_q   <= tgt_dmem_d;
      cnt_hi_q     <= cnt_hi_d;
      words_left_q <= words_left_d;
      widx_q       <= widx_d;
      imem_we_q    <= imem_we_d;
      dmem_we_q    <= dmem_we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
    end
  end

endmodule
